// File: rtl/mul_ctrl_pkg.sv
// Shared types and helpers for the shared shift-add multiplier controller.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Iteration counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after the priority
// pointer, and moves the pointer past the winner when advance is strobed.
module rr_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_advance,
    output logic [NREQ-1:0]         o_win_onehot,
    output logic [$clog2(NREQ)-1:0] o_win_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic          w_found;
    int            w_j;

    always_comb begin
        o_win_onehot = '0;
        o_win_idx    = '0;
        w_found      = 1'b0;
        w_j          = 0;
        w_idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j   = (int'(r_ptr) + i) % NREQ;
            w_idx = IW'(w_j);
            if (!w_found && i_req[w_idx]) begin
                w_found             = 1'b1;
                o_win_idx           = w_idx;
                o_win_onehot[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_win_idx == IW'(NREQ - 1)) ? '0 : o_win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequencer sharing one shift-add multiplier between NREQ clients: grants the
// datapath, strobes load/add/shift for WIDTH iterations, then pulses done.
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    m,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic                    load,
    output logic                    ad,
    output logic                    sh,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_owner;
    logic [NREQ-1:0] r_owner_oh;
    logic [NREQ-1:0] w_win_onehot;
    logic [IW-1:0]   w_win_idx;
    logic            w_req_any;
    logic            w_advance;

    assign w_req_any = |req;
    // Arbitration happens only on the edge that enters LOAD.
    assign w_advance = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_req_any;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_advance    (w_advance),
        .o_win_onehot (w_win_onehot),
        .o_win_idx    (w_win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_any) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE: w_next = w_req_any ? ST_LOAD : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_owner    <= '0;
            r_owner_oh <= '0;
        end else begin
            if (w_advance) begin
                r_owner    <= w_win_idx;
                r_owner_oh <= w_win_onehot;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= CW'(WIDTH - 1);
            end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Moore decode of registered state; ad alone follows m combinationally.
    always_comb begin
        gnt  = '0;
        done = '0;
        load = 1'b0;
        sh   = 1'b0;
        ad   = 1'b0;
        busy = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: begin
                load = 1'b1;
                gnt  = r_owner_oh;
            end
            ST_RUN: begin
                sh = 1'b1;
                ad = m;
            end
            ST_DONE: done = r_owner_oh;
            default: ;
        endcase
    end

    assign sel = r_owner;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl at WIDTH=4 and WIDTH=16, NREQ=2.
module tb_mul_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req4, req16;
    logic       m4, m16;
    logic [1:0] gnt4, done4, gnt16, done16;
    logic       sel4, sel16;
    logic       load4, ad4, sh4, busy4;
    logic       load16, ad16, sh16, busy16;

    int checks   = 0;
    int failures = 0;

    mul_share_ctrl #(.WIDTH(4), .NREQ(2)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .m(m4), .gnt(gnt4), .sel(sel4),
        .load(load4), .ad(ad4), .sh(sh4), .done(done4), .busy(busy4)
    );

    mul_share_ctrl #(.WIDTH(16), .NREQ(2)) dut16 (
        .clk(clk), .rst(rst), .req(req16), .m(m16), .gnt(gnt16), .sel(sel16),
        .load(load16), .ad(ad16), .sh(sh16), .done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; req4 = 2'b00; req16 = 2'b00; m4 = 1'b1; m16 = 1'b1;
        #3;
        checks++; if (gnt4  !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt4); end
        checks++; if (done4 !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done4); end
        checks++; if (load4 !== 1'b0)  begin failures++; $display("FAIL reset_load got=%b exp=0", load4); end
        checks++; if (ad4   !== 1'b0)  begin failures++; $display("FAIL reset_ad got=%b exp=0", ad4); end
        checks++; if (sh4   !== 1'b0)  begin failures++; $display("FAIL reset_sh got=%b exp=0", sh4); end
        checks++; if (busy4 !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy4); end
        checks++; if (sel4  !== 1'b0)  begin failures++; $display("FAIL reset_sel got=%b exp=0", sel4); end
        checks++; if (busy16 !== 1'b0 || ad16 !== 1'b0) begin failures++; $display("FAIL reset_w16 got busy=%b ad=%b exp=0,0", busy16, ad16); end
        tick; tick;
        rst = 1'b1; m4 = 1'b0; m16 = 1'b0;
    endtask

    task automatic test_single;
        logic [3:0] b;
        logic [3:0] exp_ad;
        b = 4'b1011;
        exp_ad = 4'b1011;
        req4 = 2'b01;
        tick;
        checks++; if (gnt4 !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt4); end
        checks++; if (load4 !== 1'b1 || busy4 !== 1'b1 || sh4 !== 1'b0) begin failures++; $display("FAIL single_load got load=%b busy=%b sh=%b exp=1,1,0", load4, busy4, sh4); end
        checks++; if (sel4 !== 1'b0) begin failures++; $display("FAIL single_sel_load got=%b exp=0", sel4); end
        req4 = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick;
            m4 = b[k];
            #1;
            checks++; if (sh4 !== 1'b1) begin failures++; $display("FAIL single_sh%0d got=%b exp=1", k, sh4); end
            checks++; if (ad4 !== exp_ad[k]) begin failures++; $display("FAIL single_ad%0d got=%b exp=%b", k, ad4, exp_ad[k]); end
            checks++; if (done4 !== 2'b00 || load4 !== 1'b0 || sel4 !== 1'b0) begin failures++; $display("FAIL single_run%0d got done=%b load=%b sel=%b exp=00,0,0", k, done4, load4, sel4); end
        end
        tick;
        checks++; if (done4 !== 2'b01) begin failures++; $display("FAIL single_done got=%b exp=01", done4); end
        checks++; if (sh4 !== 1'b0 || ad4 !== 1'b0) begin failures++; $display("FAIL single_done_strobes got sh=%b ad=%b exp=0,0", sh4, ad4); end
        checks++; if (sel4 !== 1'b0) begin failures++; $display("FAIL single_sel_done got=%b exp=0", sel4); end
        tick;
        checks++; if (busy4 !== 1'b0 || done4 !== 2'b00) begin failures++; $display("FAIL single_idle got busy=%b done=%b exp=0,00", busy4, done4); end
        m4 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int own;
        logic [1:0] eg, ed;
        rst = 1'b0; #2; rst = 1'b1;
        req4 = 2'b11; m4 = 1'b0;
        for (int t = 0; t < 18; t++) begin
            tick;
            own = (t / 6) % 2;
            eg = (t % 6 == 0) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
            ed = (t % 6 == 5) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (gnt4 !== eg) begin failures++; $display("FAIL b2b_gnt t=%0d got=%b exp=%b", t, gnt4, eg); end
            checks++; if (done4 !== ed) begin failures++; $display("FAIL b2b_done t=%0d got=%b exp=%b", t, done4, ed); end
            checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL b2b_busy t=%0d got=%b exp=1", t, busy4); end
            checks++; if (sel4 !== own[0]) begin failures++; $display("FAIL b2b_sel t=%0d got=%b exp=%b", t, sel4, own[0]); end
        end
        req4 = 2'b00;
        tick;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy4); end
    endtask

    task automatic test_late_req;
        req4 = 2'b01;
        tick;
        checks++; if (gnt4 !== 2'b01) begin failures++; $display("FAIL late_gnt0 got=%b exp=01", gnt4); end
        req4 = 2'b00;
        tick; tick;
        req4 = 2'b10;
        tick; tick; tick;
        checks++; if (done4 !== 2'b01 || sel4 !== 1'b0) begin failures++; $display("FAIL late_done0 got done=%b sel=%b exp=01,0", done4, sel4); end
        tick;
        checks++; if (gnt4 !== 2'b10 || load4 !== 1'b1) begin failures++; $display("FAIL late_gnt1 got gnt=%b load=%b exp=10,1", gnt4, load4); end
        checks++; if (sel4 !== 1'b1 || busy4 !== 1'b1) begin failures++; $display("FAIL late_sel1 got sel=%b busy=%b exp=1,1", sel4, busy4); end
        req4 = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (sh4 !== 1'b1 || sel4 !== 1'b1) begin failures++; $display("FAIL late_run%0d got sh=%b sel=%b exp=1,1", k, sh4, sel4); end
        end
        tick;
        checks++; if (done4 !== 2'b10) begin failures++; $display("FAIL late_done1 got=%b exp=10", done4); end
        tick;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL late_idle got=%b exp=0", busy4); end
    endtask

    task automatic test_reset_midrun;
        req4 = 2'b01;
        tick;
        checks++; if (gnt4 !== 2'b01) begin failures++; $display("FAIL mid_gnt got=%b exp=01", gnt4); end
        req4 = 2'b00;
        tick; tick; tick;
        m4 = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (gnt4 !== 2'b00 || done4 !== 2'b00 || load4 !== 1'b0) begin failures++; $display("FAIL mid_async1 got gnt=%b done=%b load=%b exp=00,00,0", gnt4, done4, load4); end
        checks++; if (ad4 !== 1'b0 || sh4 !== 1'b0 || busy4 !== 1'b0 || sel4 !== 1'b0) begin failures++; $display("FAIL mid_async2 got ad=%b sh=%b busy=%b sel=%b exp=0,0,0,0", ad4, sh4, busy4, sel4); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (done4 !== 2'b00 || busy4 !== 1'b0) begin failures++; $display("FAIL mid_held%0d got done=%b busy=%b exp=00,0", k, done4, busy4); end
        end
        rst = 1'b1; m4 = 1'b0;
        req4 = 2'b11;
        tick;
        checks++; if (gnt4 !== 2'b01 || sel4 !== 1'b0) begin failures++; $display("FAIL mid_ptr got gnt=%b sel=%b exp=01,0", gnt4, sel4); end
        req4 = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            tick;
            checks++; if (done4 !== ((k == 5) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL mid_lat k=%0d got=%b exp=%b", k, done4, (k == 5) ? 2'b01 : 2'b00); end
        end
        tick;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", busy4); end
    endtask

    task automatic test_withdraw;
        req4 = 2'b10;
        tick;
        checks++; if (gnt4 !== 2'b10) begin failures++; $display("FAIL wd_gnt1 got=%b exp=10", gnt4); end
        req4 = 2'b00;
        for (int t = 1; t <= 6; t++) begin
            tick;
            checks++; if (gnt4 !== 2'b00) begin failures++; $display("FAIL wd_nogrant t=%0d got=%b exp=00", t, gnt4); end
            if (t == 5) begin
                checks++; if (done4 !== 2'b10) begin failures++; $display("FAIL wd_done got=%b exp=10", done4); end
            end
            if (t == 6) begin
                checks++; if (busy4 !== 1'b0 || load4 !== 1'b0) begin failures++; $display("FAIL wd_idle got busy=%b load=%b exp=0,0", busy4, load4); end
            end
            if (t == 1) req4 = 2'b01;
            if (t == 2) req4 = 2'b00;
        end
    endtask

    task automatic test_width16;
        int nsh;
        logic mv;
        for (int pass = 0; pass < 2; pass++) begin
            mv = (pass == 1);
            m16 = mv;
            req16 = 2'b01;
            tick;
            checks++; if (gnt16 !== 2'b01 || load16 !== 1'b1) begin failures++; $display("FAIL w16_gnt p=%0d got gnt=%b load=%b exp=01,1", pass, gnt16, load16); end
            req16 = 2'b00;
            nsh = 0;
            for (int k = 1; k <= 16; k++) begin
                tick;
                nsh = nsh + int'(sh16);
                checks++; if (ad16 !== mv) begin failures++; $display("FAIL w16_ad p=%0d k=%0d got=%b exp=%b", pass, k, ad16, mv); end
                checks++; if (done16 !== 2'b00) begin failures++; $display("FAIL w16_early_done p=%0d k=%0d got=%b exp=00", pass, k, done16); end
            end
            tick;
            checks++; if (done16 !== 2'b01 || sh16 !== 1'b0 || ad16 !== 1'b0) begin failures++; $display("FAIL w16_done p=%0d got done=%b sh=%b ad=%b exp=01,0,0", pass, done16, sh16, ad16); end
            checks++; if (nsh != 16) begin failures++; $display("FAIL w16_shcount p=%0d got=%0d exp=16", pass, nsh); end
            tick;
            checks++; if (busy16 !== 1'b0 || sel16 !== 1'b0) begin failures++; $display("FAIL w16_idle p=%0d got busy=%b sel=%b exp=0,0", pass, busy16, sel16); end
        end
        m16 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_late_req;
        test_reset_midrun;
        test_withdraw;
        test_width16;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
